// File: rtl/mux_skid_pipe_if.sv
// Handshake bundle for mux_skid_pipe: upstream beat in, selected beat out.
interface mux_skid_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN)
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;

    modport master (
        output in_valid, sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel_err
    );

    modport slave (
        input  in_valid, sel, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel_err
    );
endinterface

// File: rtl/mux_skid_pipe.sv
// N-way operand/result select with registered output and 2-entry skid buffer.
module mux_skid_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    mux_skid_pipe_if.slave bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] main_data;
    logic             main_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             emit;

    // Unmatched select codes fall through as zero data with err set.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign accept = bus.in_valid & in_ready_q;
    assign emit   = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data   <= '0;
            main_err    <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data   <= '0;
            main_err    <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        main_data   <= sel_data;
                        main_err    <= sel_err;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                        skid_data  <= sel_data;
                        skid_err   <= sel_err;
                    end else if (accept && emit) begin
                        main_data <= sel_data;
                        main_err  <= sel_err;
                    end else if (emit) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        main_data   <= '0;
                        main_err    <= 1'b0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        main_data  <= skid_data;
                        main_err   <= skid_err;
                        skid_data  <= '0;
                        skid_err   <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    main_data   <= '0;
                    main_err    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = main_data;
    assign bus.out_sel_err = main_err;
endmodule

// File: tb/tb_mux_skid_pipe.sv
// Self-checking bench for mux_skid_pipe (NUM_IN=4 and NUM_IN=3 instances).
module tb_mux_skid_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    mux_skid_pipe_if #(.WIDTH(32), .NUM_IN(4)) i4 ();
    mux_skid_pipe_if #(.WIDTH(32), .NUM_IN(3)) i3 ();

    mux_skid_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(i4)
    );
    mux_skid_pipe #(.WIDTH(32), .NUM_IN(3)) u3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(i3)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [95:0] din;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int cyc = 0;
    exp_t q[$];
    logic hold = 1'b0;
    logic [31:0] hold_d = '0;
    logic hold_e = 1'b0;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model3(input logic [1:0] s,
                                    input logic [95:0] din);
        exp_t r;
        r.e = (s >= 2'd3);
        r.d = r.e ? 32'h0 : din[s*32 +: 32];
        return r;
    endfunction

    // One cycle on the NUM_IN=3 instance with scoreboard tracking.
    task automatic step3(input logic v, input logic [1:0] s,
                         input logic [95:0] din, input logic ordy);
        exp_t e;
        @(negedge clk);
        if (hold) begin
            chk("hold_valid", i3.out_valid, 1);
            chk("hold_data", i3.out_data, hold_d);
            chk("hold_err", i3.out_sel_err, hold_e);
        end
        i3.in_valid  = v;
        i3.sel       = s;
        i3.in_data   = din;
        i3.out_ready = ordy;
        #1;
        if (!i3.out_valid) begin
            chk("idle_data", i3.out_data, 0);
            chk("idle_err", i3.out_sel_err, 0);
        end
        if (v && i3.in_ready) begin
            q.push_back(model3(s, din));
            accepted++;
        end
        if (i3.out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sb_data", i3.out_data, e.d);
                chk("sb_err", i3.out_sel_err, e.e);
            end
        end
        hold   = i3.out_valid && !ordy;
        hold_d = i3.out_data;
        hold_e = i3.out_sel_err;
    endtask

    initial begin
        tbl[0] = '{2'd2, {32'h33, 32'h22, 32'h11}, 32'h33, 1'b0};
        tbl[1] = '{2'd3, {32'h33, 32'h22, 32'h11}, 32'h0, 1'b1};
        tbl[2] = '{2'd1, {32'h33, 32'h22, 32'h11}, 32'h22, 1'b0};
        tbl[3] = '{2'd0, {32'hc, 32'hb, 32'ha}, 32'ha, 1'b0};
        tbl[4] = '{2'd3, {32'hc, 32'hb, 32'ha}, 32'h0, 1'b1};

        i3.in_valid = 1'b0; i3.sel = '0;
        i3.in_data = '0; i3.out_ready = 1'b0;
        i4.in_valid = 1'b1; i4.sel = 2'd1;
        i4.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        i4.out_ready = 1'b1;

        // reset held with in_valid asserted
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", i4.out_valid, 0);
            chk("rst_data", i4.out_data, 0);
            chk("rst_ready", i4.in_ready, 1);
        end
        @(negedge clk);
        i4.in_valid = 1'b0;
        rst_n = 1'b1;

        // NUM_IN=4 select, one-cycle latency
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            i4.in_valid = 1'b1;
            i4.sel = 2'(s);
            @(negedge clk);
            i4.in_valid = 1'b0;
            chk("sel4_valid", i4.out_valid, 1);
            chk("sel4_data", i4.out_data, 32'h11 * (s + 1));
            chk("sel4_err", i4.out_sel_err, 0);
        end
        @(negedge clk);
        chk("sel4_drain", i4.out_valid, 0);

        // NUM_IN=3 table with out-of-range selects
        i3.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i3.in_valid = 1'b1;
            i3.sel = tbl[i].sel;
            i3.in_data = tbl[i].din;
            @(negedge clk);
            i3.in_valid = 1'b0;
            chk("tbl_valid", i3.out_valid, 1);
            chk("tbl_data", i3.out_data, tbl[i].exp_data);
            chk("tbl_err", i3.out_sel_err, tbl[i].exp_err);
        end

        // back-pressure: A main, B skid, C held upstream
        @(negedge clk);
        i4.out_ready = 1'b0;
        i4.in_valid = 1'b1;
        i4.sel = 2'd0;
        i4.in_data = {96'h0, 32'hA};
        @(negedge clk);
        chk("bp_a", i4.out_data, 32'hA);
        chk("bp_rdy1", i4.in_ready, 1);
        i4.in_data = {96'h0, 32'hB};
        @(negedge clk);
        chk("bp_full", i4.in_ready, 0);
        chk("bp_a_hold", i4.out_data, 32'hA);
        i4.in_data = {96'h0, 32'hC};
        @(negedge clk);
        chk("bp_full2", i4.in_ready, 0);
        chk("bp_a_hold2", i4.out_data, 32'hA);
        i4.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b", i4.out_data, 32'hB);
        chk("bp_b_valid", i4.out_valid, 1);
        chk("bp_rdy2", i4.in_ready, 1);
        @(negedge clk);
        chk("bp_c", i4.out_data, 32'hC);
        chk("bp_c_valid", i4.out_valid, 1);
        i4.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty", i4.out_valid, 0);
        chk("bp_empty_d", i4.out_data, 0);

        // flush in FULL with a beat offered
        i4.out_ready = 1'b0;
        i4.in_valid = 1'b1;
        i4.sel = 2'd1;
        i4.in_data = {64'h0, 32'hD1, 32'h0};
        @(negedge clk);
        i4.in_data = {64'h0, 32'hD2, 32'h0};
        @(negedge clk);
        chk("fl_full", i4.in_ready, 0);
        flush = 1'b1;
        i4.in_data = {64'h0, 32'hD3, 32'h0};
        @(negedge clk);
        flush = 1'b0;
        i4.in_valid = 1'b0;
        chk("fl_valid", i4.out_valid, 0);
        chk("fl_ready", i4.in_ready, 1);
        chk("fl_data", i4.out_data, 0);
        chk("fl_err", i4.out_sel_err, 0);
        @(negedge clk);
        chk("fl_dropped", i4.out_valid, 0);

        // random traffic vs scoreboard
        while (accepted < 10000 && cyc < 60000) begin
            step3($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  {$urandom, $urandom, $urandom},
                  $urandom_range(0, 9) < 7);
            cyc++;
        end
        if (accepted < 10000) chk("rand_budget", accepted, 10000);
        repeat (10) step3(1'b0, 2'd0, 96'h0, 1'b1);
        chk("sb_empty", q.size(), 0);
        chk("rand_idle", i3.out_valid, 0);

        // async reset mid-transfer
        @(negedge clk);
        i4.out_ready = 1'b0;
        i4.in_valid = 1'b1;
        i4.sel = 2'd3;
        @(negedge clk);
        i4.in_valid = 1'b0;
        chk("ar_loaded", i4.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", i4.out_valid, 0);
        chk("ar_data", i4.out_data, 0);
        chk("ar_ready", i4.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_gone", i4.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
